// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the frame RAM arbiter.
// Fill FSM encoding plus default RAM geometry.
package ram_port_arbiter_pkg;

    localparam int DW_DEFAULT = 12;
    localparam int AW_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/ram_fill_engine.sv
// Whole-RAM fill sequencer: walks every address once.
// Owns the fill FSM, address counter and latched fill word.
module ram_fill_engine
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT,
    parameter int ADDR_WIDTH = AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    output fill_state_e           state,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    val_d   = value;
                end
            end
            FILL: begin
                // hold at LAST so exactly DEPTH writes are issued
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            busy    <= (state_d == FILL);
            done    <= (state_d == DONE);
        end
    end

    assign state     = state_q;
    assign count     = cnt_q;
    assign fill_data = val_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1W/1R registered-read RAM between video, CPU and fill.
// Video wins reads; fill owns the write port while active.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT,
    parameter int ADDR_WIDTH = AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    output logic                  cpu_rd_ready,
    output logic                  cpu_rd_valid,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    input  logic                  cpu_wr_req,
    input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic                  cpu_wr_ready,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    fill_state_e           state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_go;

    // a simultaneous CPU write takes the cycle; caller keeps fill_start up
    assign fill_go = fill_start & ~cpu_wr_req;

    ram_fill_engine #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fill (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (fill_go),
        .value    (fill_value),
        .state    (state),
        .count    (fill_cnt),
        .fill_data(fill_data),
        .busy     (fill_busy),
        .done     (fill_done)
    );

    assign ram_read_addr = vid_req ? vid_addr : cpu_rd_addr;
    assign cpu_rd_ready  = cpu_rd_req & ~vid_req;
    assign vid_data      = ram_q;
    assign cpu_rd_data   = ram_q;
    assign cpu_wr_ready  = cpu_wr_req & (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_valid <= 1'b0;
        end else begin
            cpu_rd_valid <= cpu_rd_ready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we         <= 1'b0;
            ram_write_addr <= '0;
            ram_data       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ram_we <= cpu_wr_req;
                    if (cpu_wr_req) begin
                        ram_write_addr <= cpu_wr_addr;
                        ram_data       <= cpu_wr_data;
                    end
                end
                FILL: begin
                    ram_we         <= 1'b1;
                    ram_write_addr <= fill_cnt;
                    ram_data       <= fill_data;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural ram_block behind it.
// Read results are scored against a reference memory via queues.
module tb_ram_port_arbiter;

    localparam int DW = 12;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          cpu_rd_req;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_ready;
    logic          cpu_rd_valid;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_wr_req;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_ready;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] ram_read_addr;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] cpu_exp [$];
    logic [DW-1:0] vid_exp [$];
    logic          vid_seen = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vid_req       (vid_req),
        .vid_addr      (vid_addr),
        .vid_data      (vid_data),
        .cpu_rd_req    (cpu_rd_req),
        .cpu_rd_addr   (cpu_rd_addr),
        .cpu_rd_ready  (cpu_rd_ready),
        .cpu_rd_valid  (cpu_rd_valid),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_wr_req    (cpu_wr_req),
        .cpu_wr_addr   (cpu_wr_addr),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_wr_ready  (cpu_wr_ready),
        .fill_start    (fill_start),
        .fill_value    (fill_value),
        .fill_busy     (fill_busy),
        .fill_done     (fill_done),
        .ram_read_addr (ram_read_addr),
        .ram_write_addr(ram_write_addr),
        .ram_data      (ram_data),
        .ram_we        (ram_we),
        .ram_q         (ram_q)
    );

    // ram_block: one write port, registered read, old data on collision
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        ram_q <= mem[ram_read_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) vid_seen <= vid_req & reset_n;

    always @(negedge clk) begin
        if (reset_n && cpu_rd_valid) begin
            if (cpu_exp.size() == 0) check("cpu_rd_unexpected", 1, 0);
            else check("cpu_rd_data", cpu_rd_data, cpu_exp.pop_front());
        end
        if (vid_seen) begin
            if (vid_exp.size() == 0) check("vid_unexpected", 1, 0);
            else check("vid_data", vid_data, vid_exp.pop_front());
        end
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        @(negedge clk);
        cpu_wr_req = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (cpu_wr_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) check("cpu_wr_timeout", 0, 1);
        else ref_mem[a] = d;
        @(negedge clk);
        cpu_wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        bit ok = 0;
        @(negedge clk);
        cpu_rd_req = 1'b1; cpu_rd_addr = a;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (cpu_rd_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) check("cpu_rd_timeout", 0, 1);
        else cpu_exp.push_back(ref_mem[a]);
        @(negedge clk);
        cpu_rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) cpu_read(AW'(a));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int busy_n, wr_n, done_n, stall_n;
        bit ok;
        reset_n = 1'b0;
        vid_req = 0; vid_addr = '0;
        cpu_rd_req = 0; cpu_rd_addr = '0;
        cpu_wr_req = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
        fill_start = 0; fill_value = '0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;

        repeat (3) @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_waddr", ram_write_addr, 0);
        check("rst_wdata", ram_data, 0);
        check("rst_rd_valid", cpu_rd_valid, 0);
        check("rst_busy", fill_busy, 0);
        check("rst_done", fill_done, 0);
        reset_n = 1'b1;

        // reset in the middle of a registered write
        @(negedge clk);
        cpu_wr_req = 1; cpu_wr_addr = 4'd12; cpu_wr_data = 12'h999;
        @(negedge clk);
        cpu_wr_req = 0;
        check("mid_we_set", ram_we, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_waddr", ram_write_addr, 0);
        check("mid_rst_wdata", ram_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        cpu_write(4'd5, 12'hABC);
        cpu_read(4'd5);
        repeat (2) @(negedge clk);

        cpu_write(4'd3, 12'h321);
        @(negedge clk);
        vid_req = 1; vid_addr = 4'd3;
        cpu_rd_req = 1; cpu_rd_addr = 4'd5;
        #1;
        check("vid_block_ready", cpu_rd_ready, 0);
        check("vid_rd_addr", ram_read_addr, 3);
        vid_exp.push_back(ref_mem[3]);
        @(negedge clk);
        vid_req = 0;
        #1;
        check("cpu_after_vid_ready", cpu_rd_ready, 1);
        cpu_exp.push_back(ref_mem[5]);
        @(negedge clk);
        cpu_rd_req = 0;
        repeat (2) @(negedge clk);

        // full fill
        @(negedge clk);
        fill_start = 1; fill_value = 12'hF00;
        @(negedge clk);
        fill_start = 0;
        busy_n = 0; wr_n = 0; done_n = 0;
        for (int i = 0; i < 60; i++) begin
            if (fill_busy) busy_n++;
            if (ram_we) begin
                check("fill_addr", ram_write_addr, wr_n);
                check("fill_data", ram_data, 12'hF00);
                wr_n++;
            end
            if (fill_done) begin done_n++; break; end
            @(negedge clk);
        end
        @(negedge clk);
        check("fill_busy_cycles", busy_n, DEPTH);
        check("fill_writes", wr_n, DEPTH);
        check("fill_done_seen", done_n, 1);
        check("fill_done_pulse", fill_done, 0);
        check("fill_busy_clear", fill_busy, 0);
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 12'hF00;
        read_all();

        // CPU write stalled behind a fill
        @(negedge clk);
        fill_start = 1; fill_value = 12'h555;
        @(negedge clk);
        fill_start = 0;
        cpu_wr_req = 1; cpu_wr_addr = 4'd9; cpu_wr_data = 12'h123;
        #1;
        stall_n = 0; ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (cpu_wr_ready) begin ok = 1; break; end
            stall_n++;
            @(negedge clk); #1;
        end
        check("wr_granted", ok, 1);
        check("wr_stall_cycles", stall_n, DEPTH + 1);
        @(negedge clk);
        cpu_wr_req = 0;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 12'h555;
        ref_mem[9] = 12'h123;
        read_all();

        // reset aborts a fill while address 7 is pending
        @(negedge clk);
        fill_start = 1; fill_value = 12'h7E7;
        @(negedge clk);
        fill_start = 0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (ram_we && ram_write_addr == 4'd7) begin ok = 1; break; end
            @(negedge clk);
        end
        check("abort_reached", ok, 1);
        reset_n = 1'b0;
        #1;
        check("abort_we", ram_we, 0);
        check("abort_busy", fill_busy, 0);
        check("abort_done", fill_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fill_done || fill_busy) done_n++;
        end
        check("abort_no_resume", done_n, 0);
        for (int a = 0; a < 7; a++) ref_mem[a] = 12'h7E7;
        read_all();

        repeat (3) @(negedge clk);
        check("cpu_q_empty", cpu_exp.size(), 0);
        check("vid_q_empty", vid_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
